// File: rtl/decode_stage.sv
// decode_stage: decode stage of a 5-stage RV32I pipeline.
//
// Contains the architectural register file (written by WB, read combinationally
// with write-to-read bypass). Decodes fields, immediate and control bits, and
// registers them into the DE/EX pipeline register. Detects load-use hazards,
// stalls IF and IF/DE for one cycle and inserts a bubble.
//
// Optional feature macro: DECODE_STALL_CNT_EN
//   defined   -> stall_count counts stall_out cycles (32-bit, wrapping)
//   undefined -> stall_count is tied to zero
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   inst_in, pc_in        instruction and its PC from the IF/DE register
//   valid_in              inst_in is a real instruction
//   flush                 branch taken in EX; kill the instruction in decode
//   wb_en/addr/data       register file write port
//   stall_out             hold PC and IF/DE register (combinational)
//   ex_*                  DE/EX pipeline register outputs
//   stall_count           stall cycle counter (zero unless feature enabled)
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              inst_in,
  input  logic [XLEN-1:0]          pc_in,
  input  logic                     valid_in,
  input  logic                     flush,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     stall_out,
  output logic                     ex_valid,
  output logic [XLEN-1:0]          ex_pc,
  output logic [XLEN-1:0]          ex_rs1_data,
  output logic [XLEN-1:0]          ex_rs2_data,
  output logic [XLEN-1:0]          ex_imm,
  output logic [$clog2(NREGS)-1:0] ex_rs1_addr,
  output logic [$clog2(NREGS)-1:0] ex_rs2_addr,
  output logic [$clog2(NREGS)-1:0] ex_rd_addr,
  output logic [2:0]               ex_funct3,
  output logic                     ex_funct7b5,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_branch,
  output logic                     ex_jump,
  output logic                     ex_alu_src,
  output logic [31:0]              stall_count
);

  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Field extraction
  logic [6:0]    opcode;
  logic [AW-1:0] rs1, rs2, rd;
  assign opcode = inst_in[6:0];
  assign rd     = inst_in[7 +: AW];
  assign rs1    = inst_in[15 +: AW];
  assign rs2    = inst_in[20 +: AW];

  // Register file
  logic [XLEN-1:0] rf [NREGS];

  // NOTE: the register file has no reset branch; clearing a memory array on
  // reset turns it into a huge flop bank, and software never relies on it.
  always_ff @(posedge clk) begin
    if (wb_en && wb_addr != '0) rf[wb_addr] <= wb_data;
  end

  // x0 reads zero; a same-cycle WB write to the read index is bypassed.
  function automatic logic [XLEN-1:0] rf_read(input logic [AW-1:0] idx);
    if (idx == '0)                 return '0;
    else if (wb_en && wb_addr == idx) return wb_data;
    else                           return rf[idx];
  endfunction

  logic [XLEN-1:0] rs1_data, rs2_data;
  assign rs1_data = rf_read(rs1);
  assign rs2_data = rf_read(rs2);

  // Immediate and control decode
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic            reg_write, mem_read, mem_write, branch, jump, alu_src;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    imm32     = '0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    alu_src   = 1'b0;
    case (opcode)
      OP_R:     reg_write = 1'b1;
      OP_I_ALU: begin
        imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
        reg_write = 1'b1; alu_src = 1'b1;
      end
      OP_LOAD:  begin
        imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
        reg_write = 1'b1; mem_read = 1'b1; alu_src = 1'b1;
      end
      OP_JALR:  begin
        imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
        reg_write = 1'b1; jump = 1'b1; alu_src = 1'b1;
      end
      OP_STORE: begin
        imm32 = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
        mem_write = 1'b1; alu_src = 1'b1;
      end
      OP_BRANCH: begin
        imm32 = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                 inst_in[11:8], 1'b0};
        branch = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm32 = {inst_in[31:12], 12'b0};
        reg_write = 1'b1; alu_src = 1'b1;
      end
      OP_JAL:   begin
        imm32 = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                 inst_in[30:21], 1'b0};
        reg_write = 1'b1; jump = 1'b1; alu_src = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  // Load-use hazard: the load in EX writes a register this instruction reads.
  // rs1/rs2 are compared even for formats that do not use them (conservative).
  logic hazard;
  assign hazard = ex_valid & ex_mem_read & (ex_rd_addr != '0) & valid_in &
                  ((ex_rd_addr == rs1) | (ex_rd_addr == rs2));

  // A flush kills the younger instruction, so there is nothing left to hold.
  assign stall_out = hazard & ~flush;

  // DE/EX pipeline register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || flush || hazard) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rd_addr   <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_alu_src   <= 1'b0;
    end else begin
      ex_valid     <= valid_in;
      ex_pc        <= pc_in;
      ex_rs1_data  <= rs1_data;
      ex_rs2_data  <= rs2_data;
      ex_imm       <= imm;
      ex_rs1_addr  <= rs1;
      ex_rs2_addr  <= rs2;
      ex_rd_addr   <= rd;
      ex_funct3    <= inst_in[14:12];
      ex_funct7b5  <= inst_in[30];
      ex_reg_write <= reg_write & valid_in;
      ex_mem_read  <= mem_read  & valid_in;
      ex_mem_write <= mem_write & valid_in;
      ex_branch    <= branch    & valid_in;
      ex_jump      <= jump      & valid_in;
      ex_alu_src   <= alu_src   & valid_in;
    end
  end

`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)         stall_cnt_q <= '0;
    else if (stall_out) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage. Table-driven decode
// vectors plus hand-written hazard, flush and reset sequences.
module tb_decode_stage;

  logic        clk, rst_n;
  logic [31:0] inst_in, pc_in;
  logic        valid_in, flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall_out, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_jump, ex_alu_src;
  logic [31:0] stall_count;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .pc_in(pc_in),
    .valid_in(valid_in), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_alu_src(ex_alu_src), .stall_count(stall_count)
  );

`ifdef DECODE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [31:0] LW_X2   = 32'h0000A103; // lw  x2,0(x1)
  localparam logic [31:0] ADD_X4  = 32'h00210233; // add x4,x2,x2
  localparam logic [31:0] BEQ_8   = 32'h00208463; // beq x1,x2,8

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        e_valid;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_imm;
    logic [4:0]  e_rs1a;
    logic [4:0]  e_rs2a;
    logic [4:0]  e_rd;
    logic [2:0]  e_f3;
    logic        e_f7;
    logic [5:0]  e_ctrl; // {reg_write, mem_read, mem_write, branch, jump, alu_src}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Preloaded register value for index i.
  function automatic logic [31:0] rv(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h101;
  endfunction

  // Advance one clock; inputs are driven and outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] inst, input logic valid,
                       input logic fl);
    inst_in  = inst;
    valid_in = valid;
    flush    = fl;
    wb_en    = 1'b0;
    pc_in    = pc_in + 32'd4;
  endtask

  task automatic lw_add_pair(input string tag);
    drive(LW_X2, 1'b1, 1'b0);
    step();
    drive(ADD_X4, 1'b1, 1'b0);
    #1 check({tag, " stall_out high"}, stall_out, 1);
    step();
    check({tag, " bubble ex_valid"}, ex_valid, 0);
    check({tag, " stall_out released"}, stall_out, 0);
    step();
    check({tag, " add issued ex_valid"}, ex_valid, 1);
    check({tag, " add ex_rs1_addr"}, ex_rs1_addr, 2);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{32'h00000000, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000};
    vecs[1]  = '{32'h000281B3, 1, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 5, 0, 3, 0, 0, 6'b100000};
    vecs[2]  = '{32'h00000000, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000};
    vecs[3]  = '{32'hFFF00093, 1, 1, 0, 32'h1234, 1, 0, rv(31), 32'hFFFFFFFF, 0, 31, 1, 0, 1, 6'b100001};
    vecs[4]  = '{32'h00538413, 1, 1, 7, 32'h55, 1, 32'h55, 32'hDEADBEEF, 5, 7, 5, 8, 0, 0, 6'b100001};
    vecs[5]  = '{32'h00612623, 1, 0, 0, 0, 1, rv(2), rv(6), 12, 2, 6, 12, 2, 0, 6'b001001};
    vecs[6]  = '{32'hFE11AE23, 1, 0, 0, 0, 1, rv(3), rv(1), 32'hFFFFFFFC, 3, 1, 28, 2, 1, 6'b001001};
    vecs[7]  = '{BEQ_8,        1, 0, 0, 0, 1, rv(1), rv(2), 8, 1, 2, 8, 0, 0, 6'b000100};
    vecs[8]  = '{32'hFE209CE3, 1, 0, 0, 0, 1, rv(1), rv(2), 32'hFFFFFFF8, 1, 2, 25, 1, 1, 6'b000100};
    vecs[9]  = '{32'h12345537, 1, 0, 0, 0, 1, rv(8), rv(3), 32'h12345000, 8, 3, 10, 5, 0, 6'b100001};
    vecs[10] = '{32'h001000EF, 1, 0, 0, 0, 1, 0, rv(1), 32'h800, 0, 1, 1, 0, 0, 6'b100011};
    vecs[11] = '{32'hFFDFF06F, 1, 0, 0, 0, 1, rv(31), rv(29), 32'hFFFFFFFC, 31, 29, 0, 7, 1, 6'b100011};
    vecs[12] = '{32'h004280E7, 1, 0, 0, 0, 1, 32'hDEADBEEF, rv(4), 4, 5, 4, 1, 0, 0, 6'b100011};
    vecs[13] = '{32'h80000197, 1, 0, 0, 0, 1, 0, 0, 32'h80000000, 0, 0, 3, 0, 0, 6'b100001};
    vecs[14] = '{32'hFFFFFFFF, 1, 0, 0, 0, 1, rv(31), rv(31), 0, 31, 31, 31, 7, 1, 6'b000000};
    vecs[15] = '{32'h000281B3, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 5, 0, 3, 0, 0, 6'b000000};

    rst_n = 1'b0; inst_in = '0; pc_in = 32'h100; valid_in = 1'b0;
    flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge clk);
    step();
    check("reset ex_valid", ex_valid, 0);
    check("reset ex_pc", ex_pc, 0);
    check("reset ex_reg_write", ex_reg_write, 0);
    check("reset stall_out", stall_out, 0);
    check("reset stall_count", stall_count, 0);
    rst_n = 1'b1;

    // Preload the register file so every read has a known value.
    for (int i = 1; i < 32; i++) begin
      wb_en = 1'b1; wb_addr = 5'(i); wb_data = rv(i);
      step();
    end
    wb_en = 1'b0;

    for (int i = 0; i < 16; i++) begin
      inst_in  = vecs[i].inst;
      valid_in = vecs[i].valid;
      wb_en    = vecs[i].wb_en;
      wb_addr  = vecs[i].wb_addr;
      wb_data  = vecs[i].wb_data;
      pc_in    = 32'h200 + 32'(i) * 4;
      #1 check($sformatf("v%0d stall_out", i), stall_out, 0);
      step();
      check($sformatf("v%0d ex_valid", i), ex_valid, vecs[i].e_valid);
      check($sformatf("v%0d ex_pc", i), ex_pc, 32'h200 + 32'(i) * 4);
      check($sformatf("v%0d ex_rs1_data", i), ex_rs1_data, vecs[i].e_rs1);
      check($sformatf("v%0d ex_rs2_data", i), ex_rs2_data, vecs[i].e_rs2);
      check($sformatf("v%0d ex_imm", i), ex_imm, vecs[i].e_imm);
      check($sformatf("v%0d ex_rs1_addr", i), ex_rs1_addr, vecs[i].e_rs1a);
      check($sformatf("v%0d ex_rs2_addr", i), ex_rs2_addr, vecs[i].e_rs2a);
      check($sformatf("v%0d ex_rd_addr", i), ex_rd_addr, vecs[i].e_rd);
      check($sformatf("v%0d ex_funct3", i), ex_funct3, vecs[i].e_f3);
      check($sformatf("v%0d ex_funct7b5", i), ex_funct7b5, vecs[i].e_f7);
      check($sformatf("v%0d ctrl", i),
            {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src},
            vecs[i].e_ctrl);
    end
    wb_en = 1'b0;

    // Load-use pair: exactly one stall cycle and one bubble.
    drive(LW_X2, 1'b1, 1'b0);
    #1 check("lw no stall", stall_out, 0);
    step();
    check("lw ex_mem_read", ex_mem_read, 1);
    check("lw ex_rd_addr", ex_rd_addr, 2);
    drive(ADD_X4, 1'b1, 1'b0);
    #1 check("hz stall_out", stall_out, 1);
    step();
    check("hz bubble ex_valid", ex_valid, 0);
    check("hz bubble ex_reg_write", ex_reg_write, 0);
    check("hz stall one cycle", stall_out, 0);
    step();
    check("hz add ex_valid", ex_valid, 1);
    check("hz add ex_rs1_addr", ex_rs1_addr, 2);
    check("hz add ex_rd_addr", ex_rd_addr, 4);
    check("hz add ex_reg_write", ex_reg_write, 1);

    // Hazard and flush in the same cycle: flush wins.
    drive(LW_X2, 1'b1, 1'b0);
    step();
    drive(ADD_X4, 1'b1, 1'b1);
    #1 check("flush+hz stall_out", stall_out, 0);
    step();
    check("flush ex_valid", ex_valid, 0);
    check("flush ex_reg_write", ex_reg_write, 0);
    drive(BEQ_8, 1'b1, 1'b0);
    step();
    check("beq ex_valid", ex_valid, 1);
    check("beq ex_imm", ex_imm, 8);
    check("beq ex_branch", ex_branch, 1);

    // Stall counter: cleared by reset, then three load-use pairs.
    rst_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    check("cnt after reset", stall_count, 0);
    for (int k = 0; k < 3; k++) lw_add_pair($sformatf("pair%0d", k));
    check("cnt after 3 pairs", stall_count, CNT_EN ? 32'd3 : 32'd0);

    // Reset while a stall is pending drops the in-flight load.
    drive(LW_X2, 1'b1, 1'b0);
    step();
    drive(ADD_X4, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    check("midrst ex_valid", ex_valid, 0);
    check("midrst ex_mem_read", ex_mem_read, 0);
    check("midrst stall_out", stall_out, 0);
    check("midrst stall_count", stall_count, 0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage of the 5-stage RISC pipeline, directly downstream of the IF/DE pipeline register.
- Holds the 32x32 architectural register file, which is written by the WB stage.
- Decodes RV32I fields, immediates and control bits, then registers all results into the DE/EX pipeline register.
- Detects load-use hazards and stalls the IF and IF/DE stages for one cycle while it inserts a bubble.

Parameters:
- XLEN, 32, data and address width
- NREGS, 32, register file depth; register index width is log2(NREGS) = 5

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- inst_in  in  32  instruction from IF/DE register
- pc_in  in  32  PC of inst_in
- valid_in  in  1  inst_in is a real instruction
- flush  in  1  branch taken in EX; kill the instruction in decode
- wb_en  in  1  register file write enable
- wb_addr  in  5  register file write index
- wb_data  in  32  register file write data
- stall_out  out  1  hold PC and IF/DE register (combinational)
- ex_valid  out  1  DE/EX holds a valid instruction
- ex_pc  out  32  registered PC
- ex_rs1_data  out  32  registered rs1 operand
- ex_rs2_data  out  32  registered rs2 operand
- ex_imm  out  32  registered sign-extended immediate
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5 each  registered indices
- ex_funct3  out  3  registered funct3
- ex_funct7b5  out  1  registered inst[30]
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src  out  1 each  registered control bits
- stall_count  out  32  stall cycle counter (see Optional Feature)

Behaviour:
- Field positions: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
- Register file:
  - Write on the clk rising edge when wb_en=1 and wb_addr!=0.
  - x0 always reads 0.
  - Reads are combinational.
  - Write-to-read bypass: if wb_en=1, wb_addr!=0 and wb_addr equals the read index, the read returns wb_data in the same cycle.
  - Register file contents are not cleared by reset.
- Immediate generation by opcode:
  - I-type (0010011, 0000011, 1100111): sext(inst[31:20])
  - S-type (0100011): sext({inst[31:25], inst[11:7]})
  - B-type (1100011): sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}
  - J-type (1101111): sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - any other opcode: 0
- Control decode:
  - reg_write = R, I-ALU, load, U, JAL, JALR
  - mem_read = load
  - mem_write = store
  - branch = B-type
  - jump = JAL or JALR
  - alu_src = any opcode except R (0110011) and B
  - Unknown opcodes decode all control bits to 0.
- Load-use hazard: hazard = ex_valid & ex_mem_read & ex_rd_addr!=0 & valid_in & (ex_rd_addr==rs1 | ex_rd_addr==rs2).
  - stall_out = hazard & ~flush.
- DE/EX register update, every rising edge, in priority order:
  1. rst_n=0: all ex_* outputs become 0.
  2. flush=1: bubble. ex_valid and all control bits become 0; data fields don't-care (implementation drives them to 0).
  3. hazard=1: bubble, as in 2. The IF/DE register holds, so the same instruction is re-decoded on the next cycle, when hazard has cleared.
  4. Otherwise: load the decoded fields; ex_valid=valid_in; control bits are ANDed with valid_in.
- Latency: one cycle from inst_in to the ex_* outputs. A load-use pair costs exactly one bubble.
- Simultaneous flush and hazard: flush wins and stall_out=0, so the younger instruction is discarded rather than held.
- Reset mid-operation: any in-flight DE/EX contents are dropped. stall_out=0 while ex_valid=0.

Optional Feature:
- Macro: DECODE_STALL_CNT_EN.
- Defined: a 32-bit counter that resets to 0 on rst_n=0, increments on each cycle with stall_out=1, wraps from 0xFFFFFFFF to 0, and drives stall_count.
- Not defined: stall_count is tied to 32'd0 and no counter logic exists.

Test Plan:
- Reset, then wb_en=1, wb_addr=5, wb_data=0xDEADBEEF, and the next cycle decodes add x3,x5,x0 (0x000281B3) -> ex_rs1_data=0xDEADBEEF, ex_rs2_data=0, ex_rd_addr=3, ex_reg_write=1, ex_alu_src=0.
- Write x0=0x1234, then decode addi x1,x0,-1 (0xFFF00093) -> ex_rs1_data=0, ex_imm=0xFFFFFFFF, ex_alu_src=1.
- Write x7=0x55 in the same cycle that decode reads rs1=7 -> ex_rs1_data=0x55 (bypass).
- lw x2,0(x1) followed by add x4,x2,x2 -> stall_out=1 for exactly 1 cycle, one ex_valid=0 bubble, then the add is issued with ex_rs1_addr=2.
- Load-use hazard with flush=1 in the same cycle -> stall_out=0, ex_valid=0 next cycle; beq 0x00208463 later decodes to ex_imm=8, ex_branch=1.
- With DECODE_STALL_CNT_EN defined, 3 load-use pairs -> stall_count=3; assert rst_n=0 -> stall_count=0. With the macro not defined, stall_count stays 0.
